axi4s_pkt_framer: RTL

AXI4S_PKT_FRAMER -- requirements
Module: axi4s_pkt_framer

---
 rtl/axi4s_pkt_framer.sv | 106 ++++++++++
 1 files changed

// File: rtl/axi4s_pkt_framer.sv
// AXI4-Stream packet framer.
// Prepends a header word {MAGIC, seq} to every packet of up to PKT_LEN payload
// words. A packet closes on the PKT_LEN-th word or on an upstream s_tlast,
// whichever comes first. The output stage is a single register slice, so
// upstream backpressure follows downstream ready combinationally in BODY.
module axi4s_pkt_framer #(
    parameter int          DW      = 32,
    parameter int          PKT_LEN = 8,
    parameter logic [15:0] MAGIC   = 16'hA5A5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [15:0]   seq
);

    localparam int             CW       = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(PKT_LEN - 1);

    typedef enum logic {
        HDR  = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          load_s;
    logic          close_s;

    // Header word: tag in [31:16], sequence number in [15:0], upper bits zero.
    function automatic logic [DW-1:0] header_word(input logic [15:0] s);
        logic [DW-1:0] w;
        w        = '0;
        w[31:0]  = {MAGIC, s};
        return w;
    endfunction

    // Output-slice load condition, packet-close decision and upstream ready.
    always_comb begin
        load_s  = ~m_tvalid | m_tready;
        close_s = (cnt_r == LAST_CNT) | s_tlast;
        if (state_r == BODY) begin
            s_tready = load_s;
        end else begin
            s_tready = 1'b0;
        end
    end

    // Framing FSM with the registered output slice, payload counter and seq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= HDR;
            cnt_r    <= '0;
            seq      <= 16'd0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            case (state_r)
                HDR: begin
                    // A header goes out only when a payload word is waiting,
                    // so an empty packet can never be produced.
                    if (s_tvalid && load_s) begin
                        m_tdata  <= header_word(seq);
                        m_tlast  <= 1'b0;
                        m_tvalid <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= BODY;
                    end else if (load_s) begin
                        m_tvalid <= 1'b0;
                    end
                end
                BODY: begin
                    if (s_tvalid && load_s) begin
                        m_tdata  <= s_tdata;
                        m_tlast  <= close_s;
                        m_tvalid <= 1'b1;
                        if (close_s) begin
                            // Counter is cleared on close so it never holds PKT_LEN.
                            cnt_r   <= '0;
                            seq     <= seq + 16'd1;
                            state_r <= HDR;
                        end else begin
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end else if (load_s) begin
                        m_tvalid <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= HDR;
                    cnt_r    <= '0;
                    m_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
